// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM DAC: state encoding, sample and period sizing,
// and the comparator that turns a period count and duty value into a PWM level.
package pwm_dac_pkg;

  // Width of one audio sample and of the period counter that sweeps against it
  localparam int SAMPLE_WIDTH = 8;

  // Number of PWM ticks in one output period
  localparam int PERIOD_LEN = 256;

  // Prescaler counter width; wide enough for a divide ratio of up to 256
  localparam int PRESC_WIDTH = 8;

  // Controller state encoding, kept as plain constants for legacy tools
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  // Last period count value; a tick here closes the current period
  localparam sample_t PCNT_LAST = sample_t'(PERIOD_LEN - 1);

  // Output is high while the sweep is below the duty value, so a duty of 0 is
  // constant low and the maximum sample still leaves one low tick per period
  function automatic logic pwm_level(input sample_t pcnt, input sample_t duty);
    return (pcnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the system clock down to the PWM tick rate. The counter only runs
// while the DAC is active and snaps back to zero otherwise, so every new run
// starts with a full-length first tick.
module pwm_prescaler
  import pwm_dac_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [PRESC_WIDTH-1:0] CNT_LAST = PRESC_WIDTH'(DIV - 1);

  logic [PRESC_WIDTH-1:0] cnt_q;
  logic [PRESC_WIDTH-1:0] cnt_d;

  // Next count: hold at zero when stopped, wrap after the last divide step
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_WIDTH'(1);
    end
  end

  // Divide counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pwm_dac.sv
// Sample-driven PWM DAC. Samples arrive through a one-entry holding buffer and
// are promoted to the active duty value only at period boundaries, so each
// period is rendered with a single, stable duty. A boundary that finds no fresh
// sample repeats the previous duty and raises a sticky underrun flag.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    clear_underrun,
  output logic                    pwm_out,
  output logic                    underrun
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  sample_t    pcnt_q;
  sample_t    pcnt_d;
  sample_t    duty_q;
  sample_t    duty_d;
  sample_t    buf_q;
  sample_t    buf_d;
  logic       buf_full_q;
  logic       buf_full_d;
  logic       pwm_q;
  logic       pwm_d;
  logic       underrun_q;
  logic       underrun_d;

  logic active;
  logic tick;
  logic boundary;
  logic xfer;

  // Counting only happens while already running and still enabled; the edge
  // that sees enable low therefore clears the counters and the output at once
  assign active   = (state_q == ST_RUN) && enable;
  assign boundary = tick && (pcnt_q == PCNT_LAST);
  assign xfer     = sample_valid && !buf_full_q;

  // Ready depends only on the buffer register, never on sample_valid
  assign sample_ready = !buf_full_q;
  assign pwm_out      = pwm_q;
  assign underrun     = underrun_q;

  pwm_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (active),
    .tick_o (tick)
  );

  // Run/idle state simply follows the enable input one edge later
  always_comb begin
    state_d = enable ? ST_RUN : ST_IDLE;
  end

  // Period sweep advances once per tick and wraps naturally at the top
  always_comb begin
    pcnt_d = pcnt_q;
    if (!active) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = pcnt_q + sample_t'(1);
    end
  end

  // Output level is the registered compare of the current sweep position
  always_comb begin
    pwm_d = 1'b0;
    if (active) begin
      pwm_d = pwm_level(pcnt_q, duty_q);
    end
  end

  // Buffer and duty update: boundaries promote the buffered sample, or take a
  // sample arriving on the boundary cycle straight into duty; otherwise an
  // accepted sample waits in the buffer
  always_comb begin
    duty_d     = duty_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (boundary && buf_full_q) begin
      duty_d     = buf_q;
      buf_full_d = 1'b0;
    end else if (boundary && xfer) begin
      duty_d = sample_in;
    end else if (xfer) begin
      buf_d      = sample_in;
      buf_full_d = 1'b1;
    end
  end

  // Underrun is sticky; a new underrun on the same edge as a clear takes priority
  always_comb begin
    underrun_d = underrun_q;
    if (clear_underrun) begin
      underrun_d = 1'b0;
    end
    if (boundary && !buf_full_q && !xfer) begin
      underrun_d = 1'b1;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Period counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // PWM output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  // Sample buffer and active duty registers; reset drops any buffered sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Underrun flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

endmodule
